// File: rtl/cdc_pkg.sv
// Shared types and constants for both ends of the req/ack clock-domain crossing.
package cdc_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_HI = 2'd1,
        WAIT_LO = 2'd2
    } tx_state_t;

    localparam int CDC_MIN_SYNC_STAGES = 2;
    localparam int CDC_MAX_SYNC_STAGES = 4;

    // Fold an out-of-range depth back into the supported window.
    function automatic int clamp_stages(input int n);
        if (n < CDC_MIN_SYNC_STAGES) begin
            return CDC_MIN_SYNC_STAGES;
        end else if (n > CDC_MAX_SYNC_STAGES) begin
            return CDC_MAX_SYNC_STAGES;
        end else begin
            return n;
        end
    endfunction

endpackage

// File: rtl/sync_bit_nff.sv
// Single-bit multi-flop synchronizer, reset to 0; shared by the sender and receiver ends.
module sync_bit_nff
    import cdc_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    localparam int N = clamp_stages(SYNC_STAGES);

    logic [N-1:0] r_chain;

    // Shift the asynchronous level through the flop chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[N-2:0], i_d};
        end
    end

    assign o_q = r_chain[N-1];

endmodule

// File: rtl/cdc_handshake_tx.sv
// Source-side sender of a 4-phase req/ack crossing. Optional per-wait abort
// with sticky timeout_err is enabled by defining CDC_TX_TIMEOUT_EN.
module cdc_handshake_tx
    import cdc_pkg::*;
#(
    parameter int D           = 8,
    parameter int SYNC_STAGES = 2
`ifdef CDC_TX_TIMEOUT_EN
    , parameter int TIMEOUT   = 255
`endif
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [D-1:0] data_in,
    output logic         xfer_req,
    output logic [D-1:0] xfer_data,
    input  logic         xfer_ack,
    output logic         done
`ifdef CDC_TX_TIMEOUT_EN
    , output logic       timeout_err
`endif
);

    tx_state_t    r_state;
    logic         r_req;
    logic         r_done;
    logic [D-1:0] r_data;
    logic         w_ack_s;
    logic         w_in_ready;

    sync_bit_nff #(.SYNC_STAGES(SYNC_STAGES)) u_ack_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (xfer_ack),
        .o_q   (w_ack_s)
    );

    // A lingering ack from the previous transfer blocks new captures.
    assign w_in_ready = (r_state == IDLE) && !w_ack_s;
    assign in_ready   = w_in_ready;
    assign xfer_req   = r_req;
    assign xfer_data  = r_data;
    assign done       = r_done;

`ifdef CDC_TX_TIMEOUT_EN
    localparam logic [15:0] TMO = 16'(TIMEOUT);

    logic [15:0] r_wait_cnt;
    logic [15:0] w_wait_next;
    logic        w_expired;
    logic        r_aborted;
    logic        r_timeout_err;

    assign w_wait_next = r_wait_cnt + 16'd1;
    assign w_expired   = (w_wait_next == TMO);
    assign timeout_err = r_timeout_err;
`endif

    // Handshake sequencer; req, data and done are all driven from flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_req   <= 1'b0;
            r_data  <= '0;
            r_done  <= 1'b0;
`ifdef CDC_TX_TIMEOUT_EN
            r_wait_cnt    <= 16'd0;
            r_aborted     <= 1'b0;
            r_timeout_err <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (in_valid && w_in_ready) begin
                        r_data  <= data_in;
                        r_req   <= 1'b1;
                        r_state <= WAIT_HI;
`ifdef CDC_TX_TIMEOUT_EN
                        r_wait_cnt <= 16'd0;
                        r_aborted  <= 1'b0;
`endif
                    end
                end
                WAIT_HI: begin
                    if (w_ack_s) begin
                        r_req   <= 1'b0;
                        r_state <= WAIT_LO;
`ifdef CDC_TX_TIMEOUT_EN
                        r_wait_cnt <= 16'd0;
                    end else if (w_expired) begin
                        r_req         <= 1'b0;
                        r_state       <= WAIT_LO;
                        r_wait_cnt    <= 16'd0;
                        r_aborted     <= 1'b1;
                        r_timeout_err <= 1'b1;
                    end else begin
                        r_wait_cnt <= w_wait_next;
`endif
                    end
                end
                WAIT_LO: begin
                    if (!w_ack_s) begin
                        r_state <= IDLE;
`ifdef CDC_TX_TIMEOUT_EN
                        // An aborted transfer never reports completion.
                        r_done     <= !r_aborted;
                        r_wait_cnt <= 16'd0;
                    end else if (w_expired) begin
                        r_state       <= IDLE;
                        r_wait_cnt    <= 16'd0;
                        r_timeout_err <= 1'b1;
                    end else begin
                        r_wait_cnt <= w_wait_next;
`else
                        r_done <= 1'b1;
`endif
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

endmodule
